// File: rtl/fifo_rd_stream.sv
// Read-side consumer for the async FIFO. It pops show-ahead words into a 2-entry skid buffer
// and presents them as a registered valid/ready stream, keeping a debug handshake counter.
module fifo_rd_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rpull,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_out;
  logic [DATA_WIDTH-1:0] r_skid;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic w_pop;
  logic w_take;
  logic w_out_from_fifo;
  logic w_out_from_skid;
  logic w_skid_from_fifo;

  // The pull never looks at m_ready: the skid slot absorbs the word in flight.
  assign w_pop    = rrst_n && !flush && !rempty && (r_state != ST_TWO);
  assign w_take   = m_valid && m_ready;

  assign rpull    = w_pop;
  assign m_valid  = (r_state != ST_EMPTY);
  assign m_data   = r_out;
  assign xfer_cnt = r_cnt;

  // Next occupancy and which register loads from where.
  always_comb begin
    w_state_nxt      = r_state;
    w_out_from_fifo  = 1'b0;
    w_out_from_skid  = 1'b0;
    w_skid_from_fifo = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_pop) begin
            w_out_from_fifo = 1'b1;
            w_state_nxt     = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_pop && w_take) begin
            w_out_from_fifo = 1'b1;
          end else if (w_pop) begin
            w_skid_from_fifo = 1'b1;
            w_state_nxt      = ST_TWO;
          end else if (w_take) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_take) begin
            w_out_from_skid = 1'b1;
            w_state_nxt     = ST_ONE;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data path; flush loads nothing so m_data holds its last value.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_out_from_fifo) begin
        r_out <= rdata;
      end else if (w_out_from_skid) begin
        r_out <= r_skid;
      end
      if (w_skid_from_fifo) begin
        r_skid <= rdata;
      end
    end
  end

  // Handshake counter, still counting on a flush cycle and wrapping naturally.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_cnt <= '0;
    end else if (w_take) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a directed vector table followed by FIFO-model driven
// sequences for throughput, backpressure, over-read, flush and mid-stream reset.
module tb_fifo_rd_stream;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rpull;
  logic          flush;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [CW-1:0] xfer_cnt;

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rempty   (rempty),
    .rdata    (rdata),
    .rpull    (rpull),
    .flush    (flush),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_ready  (m_ready),
    .xfer_cnt (xfer_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One table row: inputs for a cycle, outputs expected just before that cycle's edge.
  typedef struct {
    logic          rst_n;
    logic          fl;
    logic          emp;
    logic [DW-1:0] d;
    logic          rdy;
    logic          e_pull;
    logic          e_valid;
    logic [DW-1:0] e_data;
    logic [CW-1:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, input logic fl, input logic emp,
                              input logic [DW-1:0] d, input logic rdy, input logic e_pull,
                              input logic e_valid, input logic [DW-1:0] e_data,
                              input logic [CW-1:0] e_cnt);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.emp = emp; v.d = d; v.rdy = rdy;
    v.e_pull = e_pull; v.e_valid = e_valid; v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  // FIFO model and scoreboard state
  int unsigned q[$];
  int unsigned rx[$];
  int          rx_cyc[$];
  int          cyc = 0;
  int          occ = 0;
  int          pops = 0;
  int          pull_empty_err = 0;
  int          occ_err = 0;
  int          stab_err = 0;
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic refresh();
    rempty = (q.size() == 0);
    if (q.size() != 0) rdata = q[0];
  endtask

  task automatic fill(input int unsigned first, input int unsigned n);
    q.delete();
    for (int unsigned i = 0; i < n; i++) q.push_back(first + i);
    refresh();
  endtask

  // Sample before the edge, advance one clock, then update the FIFO model at the falling edge.
  task automatic step();
    logic s_pull, s_take, s_valid, s_rst, s_fl;
    logic [DW-1:0] s_data;
    #1;
    s_pull  = rpull;
    s_valid = m_valid;
    s_take  = m_valid && m_ready;
    s_data  = m_data;
    s_rst   = rrst_n;
    s_fl    = flush;
    if (s_pull && rempty) pull_empty_err++;
    if (occ == 2 && s_pull) occ_err++;
    if (prev_hold && (!s_valid || s_data !== prev_data)) stab_err++;
    prev_hold = s_rst && !s_fl && s_valid && !m_ready;
    prev_data = s_data;
    @(posedge rclk);
    cyc++;
    if (!s_rst) begin
      occ = 0;
    end else begin
      if (s_pull) begin
        void'(q.pop_front());
        pops++;
        occ++;
      end
      if (s_take) begin
        rx.push_back(s_data);
        rx_cyc.push_back(cyc);
        occ--;
      end
      if (s_fl) occ = 0;
    end
    if (occ > 2) occ_err++;
    @(negedge rclk);
    refresh();
  endtask

  task automatic clear_rx();
    rx.delete();
    rx_cyc.delete();
  endtask

  function automatic logic [63:0] rx_at(input int i);
    return (i < rx.size()) ? 64'(rx[i]) : 64'hDEAD_BEEF_0BAD_F00D;
  endfunction

  vec_t vt[14];

  initial begin
    int unsigned c0;
    int          p0;
    int          bad;
    int          n;

    vt[0]  = mk(0, 0, 0, 32'hAA, 0,  0, 0, 32'h00, 0);
    vt[1]  = mk(1, 0, 0, 32'h11, 0,  1, 0, 32'h00, 0);
    vt[2]  = mk(1, 0, 0, 32'h22, 0,  1, 1, 32'h11, 0);
    vt[3]  = mk(1, 0, 0, 32'h33, 0,  0, 1, 32'h11, 0);
    vt[4]  = mk(1, 0, 0, 32'h33, 1,  0, 1, 32'h11, 0);
    vt[5]  = mk(1, 0, 0, 32'h33, 1,  1, 1, 32'h22, 1);
    vt[6]  = mk(1, 0, 1, 32'h44, 1,  0, 1, 32'h33, 2);
    vt[7]  = mk(1, 0, 1, 32'h44, 1,  0, 0, 32'h33, 3);
    vt[8]  = mk(1, 0, 0, 32'h55, 1,  1, 0, 32'h33, 3);
    vt[9]  = mk(1, 0, 0, 32'h66, 0,  1, 1, 32'h55, 3);
    vt[10] = mk(1, 1, 0, 32'h77, 1,  0, 1, 32'h55, 3);
    vt[11] = mk(1, 0, 0, 32'h77, 1,  1, 0, 32'h55, 4);
    vt[12] = mk(1, 1, 0, 32'h88, 0,  0, 1, 32'h77, 4);
    vt[13] = mk(1, 0, 1, 32'h88, 0,  0, 0, 32'h77, 4);

    rrst_n = 1'b0; flush = 1'b0; m_ready = 1'b0; rempty = 1'b1; rdata = '0;
    @(posedge rclk); @(posedge rclk);
    @(negedge rclk);

    // Directed table
    for (int i = 0; i < 14; i++) begin
      rrst_n = vt[i].rst_n; flush = vt[i].fl; rempty = vt[i].emp;
      rdata = vt[i].d; m_ready = vt[i].rdy;
      #1;
      check($sformatf("vec%0d_rpull", i),   64'(rpull),    64'(vt[i].e_pull));
      check($sformatf("vec%0d_m_valid", i), 64'(m_valid),  64'(vt[i].e_valid));
      check($sformatf("vec%0d_m_data", i),  64'(m_data),   64'(vt[i].e_data));
      check($sformatf("vec%0d_xfer_cnt", i), 64'(xfer_cnt), 64'(vt[i].e_cnt));
      @(negedge rclk);
    end
    flush = 1'b0;

    // 1: streaming 2..17 with m_ready held
    q.delete(); refresh();
    rrst_n = 1'b0; step(); step(); rrst_n = 1'b1;
    fill(2, 16);
    m_ready = 1'b1;
    clear_rx();
    n = 0;
    while (rx.size() < 16 && n < 60) begin step(); n++; end
    step(); step();
    check("s1_count", 64'(rx.size()), 64'd16);
    for (int i = 0; i < 16; i++) check($sformatf("s1_word%0d", i), rx_at(i), 64'(i + 2));
    if (rx.size() == 16) check("s1_back_to_back", 64'(rx_cyc[15] - rx_cyc[0]), 64'd15);
    check("s1_xfer_cnt", 64'(xfer_cnt), 64'd16);
    check("s1_fifo_empty", 64'(q.size()), 64'd0);
    check("s1_pull_while_empty", 64'(pull_empty_err), 64'd0);

    // 2: m_ready toggling every cycle
    fill(20, 20);
    clear_rx();
    n = 0;
    while (rx.size() < 20 && n < 200) begin
      m_ready = (n % 2 == 0);
      step();
      n++;
    end
    m_ready = 1'b1; step();
    for (int i = 0; i < 20; i++) check($sformatf("s2_word%0d", i), rx_at(i), 64'(i + 20));
    check("s2_stable_under_stall", 64'(stab_err), 64'd0);
    check("s2_occupancy", 64'(occ_err), 64'd0);
    check("s2_xfer_cnt", 64'(xfer_cnt), 64'd36);

    // 3: ten stalled cycles, then release
    fill(50, 10);
    m_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 10; i++) step();
    check("s3_pops_while_stalled", 64'(pops - p0), 64'd2);
    check("s3_m_valid", 64'(m_valid), 64'd1);
    check("s3_m_data_first", 64'(m_data), 64'd50);
    m_ready = 1'b1;
    clear_rx();
    n = 0;
    while (rx.size() < 3 && n < 20) begin step(); n++; end
    check("s3_word0", rx_at(0), 64'd50);
    check("s3_word1", rx_at(1), 64'd51);
    check("s3_word2", rx_at(2), 64'd52);
    if (rx.size() >= 3) begin
      check("s3_gap01", 64'(rx_cyc[1] - rx_cyc[0]), 64'd1);
      check("s3_gap12", 64'(rx_cyc[2] - rx_cyc[1]), 64'd1);
    end
    n = 0;
    while ((q.size() != 0 || m_valid) && n < 40) begin step(); n++; end

    // 4: over-read of an empty FIFO
    q.delete(); refresh();
    c0 = xfer_cnt;
    m_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (rpull || m_valid) bad++;
      step();
    end
    check("s4_no_pull_no_valid", 64'(bad), 64'd0);
    check("s4_xfer_cnt", 64'(xfer_cnt), 64'(c0));

    // 5: flush in TWO with m_ready low
    fill(60, 10);
    m_ready = 1'b0;
    step(); step(); step();
    check("s5_valid_before_flush", 64'(m_valid), 64'd1);
    c0 = xfer_cnt;
    p0 = pops;
    flush = 1'b1;
    #1;
    check("s5_rpull_in_flush", 64'(rpull), 64'd0);
    step();
    flush = 1'b0;
    check("s5_no_pop_in_flush", 64'(pops - p0), 64'd0);
    check("s5_m_valid_after", 64'(m_valid), 64'd0);
    check("s5_xfer_cnt", 64'(xfer_cnt), 64'(c0));
    m_ready = 1'b1;
    clear_rx();
    n = 0;
    while (rx.size() < 1 && n < 10) begin step(); n++; end
    check("s5_next_word", rx_at(0), 64'd62);
    n = 0;
    while ((q.size() != 0 || m_valid) && n < 40) begin step(); n++; end

    // 6: two-cycle reset mid-stream, then a refilled FIFO
    fill(70, 10);
    m_ready = 1'b1;
    step(); step(); step(); step();
    rrst_n = 1'b0;
    #1;
    check("s6_rpull_reset0", 64'(rpull), 64'd0);
    step();
    check("s6_m_valid", 64'(m_valid), 64'd0);
    check("s6_m_data", 64'(m_data), 64'd0);
    check("s6_xfer_cnt", 64'(xfer_cnt), 64'd0);
    check("s6_rpull_reset1", 64'(rpull), 64'd0);
    step();
    rrst_n = 1'b1;
    fill(100, 5);
    clear_rx();
    n = 0;
    while (rx.size() < 5 && n < 30) begin step(); n++; end
    for (int i = 0; i < 5; i++) check($sformatf("s6_word%0d", i), rx_at(i), 64'(i + 100));
    check("s6_xfer_cnt_after", 64'(xfer_cnt), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side consumer for the project's asynchronous FIFO. It drives the FIFO's show-ahead read port (`rpull`/`rempty`/`rdata`) and presents the words downstream as a registered valid/ready stream. A 2-entry skid buffer gives full throughput (one word per `rclk`) with no combinational path from `m_ready` to `rpull`. The block lives entirely in the FIFO read clock domain and also keeps a handshake counter for debug and bench checking.

## Interface
- `DATA_WIDTH`, default 32: word width; must match the FIFO.
- `CNT_WIDTH`, default 32: width of `xfer_cnt`.

Ports:
- `rclk`  in  1: read-domain clock. Everything is on the rising edge.
- `rrst_n`  in  1: reset. Synchronous, active-low; sampled on the `rclk` rising edge.
- `rempty`  in  1: FIFO empty flag. While 0, `rdata` holds the head word (show-ahead).
- `rdata`  in  DATA_WIDTH: FIFO head word.
- `rpull`  out  1: pop request to the FIFO. The head pops on an `rclk` edge where `rpull=1` and `rempty=0`.
- `flush`  in  1: synchronous discard of all buffered words.
- `m_valid`  out  1: downstream word valid.
- `m_data`  out  DATA_WIDTH: downstream word.
- `m_ready`  in  1: downstream accept.
- `xfer_cnt`  out  CNT_WIDTH: number of completed downstream handshakes.

## Operation
- Storage is an output register `out` (drives `m_data`) plus one skid register `skid`. A 2-bit occupancy state holds the fill level:
  - EMPTY: 0 words.
  - ONE: `out` valid.
  - TWO: `out` and `skid` valid.
- `m_valid = (state != EMPTY)`, decoded from registers only.
- `rpull = rrst_n && !flush && !rempty && (state != TWO)`.
  - Combinational from `rempty` and registers only; never depends on `m_ready`.
- `pop = rpull` (it already implies `!rempty`). `take = m_valid && m_ready`.
- State transitions, applied when `rrst_n=1` and `flush=0`:
  - EMPTY, pop: `out<=rdata`; next ONE.
  - ONE, pop & take: `out<=rdata`; stay ONE.
  - ONE, pop & !take: `skid<=rdata`; next TWO.
  - ONE, !pop & take: next EMPTY.
  - TWO, take: `out<=skid`; next ONE. No pop is possible in TWO.
  - Any other combination: hold.
- Ordering: words leave in exactly FIFO pop order; none are dropped or duplicated.
- `m_data` holds its last value while `m_valid=0`. It must not change while `m_valid=1 && !m_ready`.
- `xfer_cnt` increments by 1 on every `take`, including during a `flush` cycle. It wraps modulo 2^CNT_WIDTH and is not cleared by `flush`.
- `flush=1`:
  - next state EMPTY.
  - `rpull=0` that cycle, so no FIFO pop.
  - `out`/`skid` contents are don't-care; `m_data` holds.
- Reset (`rrst_n=0` at an edge): state EMPTY, `m_valid=0`, `m_data=0`, `skid=0`, `xfer_cnt=0`. `rpull=0` while `rrst_n=0`.
- Reset mid-stream: buffered words are lost. The FIFO is reset alongside, so no resync is needed.

## Timing
- Latency: FIFO head pulled at edge k gives `m_valid=1` with that word in the cycle after edge k (1 cycle).
- Throughput: with `m_ready` held 1 and `rempty` held 0, one word per cycle after the first, and the state stays ONE.
- Backpressure: after `m_ready` drops, at most one more word is popped (state becomes TWO). `rpull` then stays 0 until the next `take`.
- Simultaneous `take` and `flush`: the handshake counts; the word in `skid` is discarded.
- `rempty` rising with `rpull=1` in the same cycle: the FIFO ignores the pull. The block samples `rempty` combinationally, so no pop is counted.

## Test plan
1. Reset, then FIFO holding 2..17 (16 words) with `m_ready=1` constantly:
   - `m_data` sequence is 2..17, one per cycle after the first.
   - `xfer_cnt=16`.
   - FIFO ends empty, with no extra `rpull` while `rempty=1`.
2. FIFO holding 20..39, `m_ready` toggling 1/0 every cycle:
   - all 20 words arrive in order.
   - `m_data` is stable during every `m_valid && !m_ready` cycle.
   - state never exceeds TWO; `rpull=0` whenever state is TWO.
3. `m_ready=0` for 10 cycles with the FIFO non-empty:
   - exactly 2 pops occur.
   - `m_valid=1` with the first word.
   - on release, the first two words come out back-to-back, then the third.
4. Empty FIFO with `m_ready=1` (over-read):
   - `rpull=0` and `m_valid=0` throughout; `xfer_cnt` unchanged.
5. Flush while in state TWO with `m_ready=0`:
   - next cycle `m_valid=0`, no pop during the flush cycle.
   - the next word delivered is the FIFO head at flush+1.
   - `xfer_cnt` unchanged.
6. `rrst_n=0` asserted mid-stream for 2 cycles:
   - on the first reset edge, `m_valid=0`, `m_data=0`, `xfer_cnt=0`, and `rpull=0` throughout reset.
   - after release with a refilled FIFO, the stream resumes from the new head.
